// File: rtl/axis_noise_gate_mc_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
// Shared types and helpers for the multi-channel AXIS noise gate.
//   gate_state_t : per-channel gate state (CLOSED/ATTACK/OPEN/HOLD/RELEASE)
//   sat_abs()    : magnitude of a w-bit signed sample. The input is passed
//                  sign-extended to ABS_W bits. The most negative w-bit value
//                  saturates to 2**(w-1)-1.
// ----------------------------------------------------------------------------
package audio_pkg;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } gate_state_t;

    localparam int unsigned ABS_W = 64;

    function automatic logic [ABS_W-1:0] sat_abs(input logic signed [ABS_W-1:0] x,
                                                 input int unsigned             w);
        logic signed [ABS_W-1:0] most_neg;
        logic        [ABS_W-1:0] one;
        one      = {{(ABS_W-1){1'b0}}, 1'b1};
        most_neg = {ABS_W{1'b1}} << (w - 1);
        if (x == most_neg)
            return (one << (w - 1)) - one;
        else if (x[ABS_W-1])
            return -x;
        else
            return x;
    endfunction

endpackage

// File: rtl/axis_noise_gate_mc_ch_fsm.sv
// ----------------------------------------------------------------------------
// noise_gate_ch_fsm
// One channel of the noise gate: state, gain and hold counter.
// The FSM advances only when beat_i is high. gain_o is the gain that
// applies to the sample of the current beat, i.e. the post-update value.
// Optional feature (macro NOISE_GATE_STATUS_EN): is_open_o reports the
// state held in the register (ATTACK, OPEN or HOLD).
// Ports:
//   clk_i, resetn_i    clock, synchronous active-low reset
//   gate_enable_i      0 forces CLOSED, gain 0, hold 0
//   beat_i             accepted beat belonging to this channel
//   abs_i              |x| of the current sample
//   open_thr_i, close_thr_i, hold_samples_i, attack_step_i, release_step_i
//   gain_o             gain for the current sample
//   is_open_o          (NOISE_GATE_STATUS_EN only) registered open flag
// ----------------------------------------------------------------------------
module noise_gate_ch_fsm
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned GAIN_W   = 8,
    parameter int unsigned HOLD_W   = 16
) (
    input  logic                clk_i,
    input  logic                resetn_i,
    input  logic                gate_enable_i,
    input  logic                beat_i,
    input  logic [SAMPLE_W-2:0] abs_i,
    input  logic [SAMPLE_W-2:0] open_thr_i,
    input  logic [SAMPLE_W-2:0] close_thr_i,
    input  logic [HOLD_W-1:0]   hold_samples_i,
    input  logic [GAIN_W-1:0]   attack_step_i,
    input  logic [GAIN_W-1:0]   release_step_i,
    output logic [GAIN_W-1:0]   gain_o
`ifdef NOISE_GATE_STATUS_EN
    ,
    output logic                is_open_o
`endif
);

    localparam logic [GAIN_W-1:0] GMAX = '1;

    gate_state_t       state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic              loud, quiet;
    logic [GAIN_W:0]   gain_sum;
    logic [GAIN_W-1:0] gain_up, gain_dn;

    assign loud     = (abs_i >= open_thr_i);
    assign quiet    = (abs_i <  close_thr_i);
    assign gain_sum = {1'b0, gain_q} + {1'b0, attack_step_i};
    assign gain_up  = gain_sum[GAIN_W] ? GMAX : gain_sum[GAIN_W-1:0];
    assign gain_dn  = (gain_q > release_step_i) ? (gain_q - release_step_i) : '0;

    // A transition beat also performs the destination state's gain action,
    // so CLOSED->ATTACK ramps immediately and HOLD->RELEASE drops immediately.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        if (!gate_enable_i) begin
            state_d = CLOSED;
            gain_d  = '0;
            hold_d  = '0;
        end else if (beat_i) begin
            unique case (state_q)
                CLOSED: begin
                    if (loud) begin
                        gain_d  = gain_up;
                        state_d = (gain_up == GMAX) ? OPEN : ATTACK;
                    end
                end
                ATTACK: begin
                    gain_d  = gain_up;
                    state_d = (gain_up == GMAX) ? OPEN : ATTACK;
                end
                OPEN: begin
                    if (quiet) begin
                        state_d = HOLD;
                        hold_d  = hold_samples_i;
                    end
                end
                HOLD: begin
                    if (loud) begin
                        state_d = OPEN;
                    end else if (hold_q == '0) begin
                        gain_d  = gain_dn;
                        state_d = (gain_dn == '0) ? CLOSED : RELEASE;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                RELEASE: begin
                    if (loud) begin
                        gain_d  = gain_up;
                        state_d = (gain_up == GMAX) ? OPEN : ATTACK;
                    end else begin
                        gain_d  = gain_dn;
                        state_d = (gain_dn == '0) ? CLOSED : RELEASE;
                    end
                end
                default: begin
                    state_d = CLOSED;
                    gain_d  = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= CLOSED;
            gain_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            hold_q  <= hold_d;
        end
    end

    assign gain_o = gain_d;

`ifdef NOISE_GATE_STATUS_EN
    assign is_open_o = (state_q == ATTACK) || (state_q == OPEN) || (state_q == HOLD);
`else
`endif

endmodule

// File: rtl/axis_noise_gate_mc.sv
// ----------------------------------------------------------------------------
// axis_noise_gate_mc
// Multi-channel AXIS noise gate with hysteresis, hold and gain ramps.
// Channels are interleaved on the stream; ch_idx tracks which channel the
// current beat belongs to and resyncs to 0 after any beat with last set.
// Optional feature (macro NOISE_GATE_STATUS_EN): gate_open[NUM_CH-1:0].
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   gate_enable                      0 = bypass, all channels CLOSED
//   open_thr, close_thr              hysteresis thresholds on |x|
//   hold_samples                     hold duration in channel samples
//   attack_step, release_step        gain ramp steps per sample
//   s_axis_data/valid/ready/last     input stream
//   m_axis_data/valid/ready/last     output stream (1-cycle latency)
//   gate_open                        (NOISE_GATE_STATUS_EN only)
// ----------------------------------------------------------------------------
module axis_noise_gate_mc
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned GAIN_W   = 8,
    parameter int unsigned HOLD_W   = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                gate_enable,
    input  logic [SAMPLE_W-2:0] open_thr,
    input  logic [SAMPLE_W-2:0] close_thr,
    input  logic [HOLD_W-1:0]   hold_samples,
    input  logic [GAIN_W-1:0]   attack_step,
    input  logic [GAIN_W-1:0]   release_step,
    input  logic [WORD_W-1:0]   s_axis_data,
    input  logic                s_axis_valid,
    output logic                s_axis_ready,
    input  logic                s_axis_last,
    output logic [WORD_W-1:0]   m_axis_data,
    output logic                m_axis_valid,
    input  logic                m_axis_ready,
    output logic                m_axis_last
`ifdef NOISE_GATE_STATUS_EN
    ,
    output logic [NUM_CH-1:0]   gate_open
`endif
);

    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] GMAX = '1;

    logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
    logic [WORD_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q;
    logic              m_last_q;
    logic              accept;

    logic signed [SAMPLE_W-1:0] x_s;
    logic        [SAMPLE_W-2:0] abs_x;
    logic        [GAIN_W-1:0]   ch_gain [NUM_CH];
    logic        [GAIN_W-1:0]   gain_sel;
    logic signed [PROD_W-1:0]   prod;
    logic        [SAMPLE_W-1:0] y;

    assign s_axis_ready = resetn && (!m_valid_q || m_axis_ready);
    assign accept       = s_axis_valid && s_axis_ready;

    assign ch_idx_d = (s_axis_last || (ch_idx_q == CH_W'(NUM_CH - 1))) ? '0 : ch_idx_q + 1'b1;

    assign x_s   = s_axis_data[SAMPLE_W-1:0];
    assign abs_x = (SAMPLE_W-1)'(sat_abs({{(ABS_W-SAMPLE_W){x_s[SAMPLE_W-1]}}, x_s}, SAMPLE_W));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        noise_gate_ch_fsm #(
            .SAMPLE_W (SAMPLE_W),
            .GAIN_W   (GAIN_W),
            .HOLD_W   (HOLD_W)
        ) u_fsm (
            .clk_i          (clk),
            .resetn_i       (resetn),
            .gate_enable_i  (gate_enable),
            .beat_i         (accept && (ch_idx_q == CH_W'(c))),
            .abs_i          (abs_x),
            .open_thr_i     (open_thr),
            .close_thr_i    (close_thr),
            .hold_samples_i (hold_samples),
            .attack_step_i  (attack_step),
            .release_step_i (release_step),
            .gain_o         (ch_gain[c])
`ifdef NOISE_GATE_STATUS_EN
            ,
            .is_open_o      (gate_open[c])
`endif
        );
    end

    assign gain_sel = ch_gain[ch_idx_q];

    // Unity gain must reproduce x exactly; the scaled path alone would lose 1/256.
    assign prod = PROD_W'(x_s) * PROD_W'($signed({1'b0, gain_sel}));
    assign y    = (gain_sel == GMAX) ? x_s : SAMPLE_W'(prod >>> GAIN_W);

    assign m_data_d = gate_enable ? {s_axis_data[WORD_W-1:SAMPLE_W], y} : s_axis_data;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            ch_idx_q  <= '0;
        end else begin
            if (accept) begin
                m_data_q  <= m_data_d;
                m_valid_q <= 1'b1;
                m_last_q  <= s_axis_last;
                ch_idx_q  <= ch_idx_d;
            end else if (m_axis_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_data  = m_data_q;
    assign m_axis_valid = m_valid_q;
    assign m_axis_last  = m_last_q;

endmodule

// File: tb/tb_axis_noise_gate_mc.sv
// ----------------------------------------------------------------------------
// tb_axis_noise_gate_mc
// Directed, scoreboard-based bench for axis_noise_gate_mc (NUM_CH=2).
// Expected beats are pushed when a beat is accepted and popped by a monitor
// whenever the output transfers.
// ----------------------------------------------------------------------------
module tb_axis_noise_gate_mc;

    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned GAIN_W   = 8;
    localparam int unsigned HOLD_W   = 16;

    logic                clk = 1'b0;
    logic                resetn;
    logic                gate_enable;
    logic [SAMPLE_W-2:0] open_thr;
    logic [SAMPLE_W-2:0] close_thr;
    logic [HOLD_W-1:0]   hold_samples;
    logic [GAIN_W-1:0]   attack_step;
    logic [GAIN_W-1:0]   release_step;
    logic [WORD_W-1:0]   s_axis_data;
    logic                s_axis_valid;
    logic                s_axis_ready;
    logic                s_axis_last;
    logic [WORD_W-1:0]   m_axis_data;
    logic                m_axis_valid;
    logic                m_axis_ready;
    logic                m_axis_last;
`ifdef NOISE_GATE_STATUS_EN
    logic [NUM_CH-1:0]   gate_open;
`endif

    always #5 clk = ~clk;

    axis_noise_gate_mc #(
        .SAMPLE_W (SAMPLE_W),
        .WORD_W   (WORD_W),
        .NUM_CH   (NUM_CH),
        .GAIN_W   (GAIN_W),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .gate_enable  (gate_enable),
        .open_thr     (open_thr),
        .close_thr    (close_thr),
        .hold_samples (hold_samples),
        .attack_step  (attack_step),
        .release_step (release_step),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_last  (s_axis_last),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last)
`ifdef NOISE_GATE_STATUS_EN
        ,
        .gate_open    (gate_open)
`endif
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [32:0] sb [$];
    logic [32:0] exp_beat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive one beat (called just after a rising edge) and push its expected
    // output once the DUT is ready to take it.
    task automatic send(input logic [31:0] d, input logic l, input logic [31:0] exp_d);
        int unsigned n = 0;
        s_axis_data  = d;
        s_axis_last  = l;
        s_axis_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_ready) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", {63'b0, s_axis_ready}, 64'd1);
                break;
            end
        end
        sb.push_back({l, exp_d});
        @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resetn && m_axis_valid && m_axis_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL sb_underflow: observed %h with nothing expected", {m_axis_last, m_axis_data});
            end else begin
                exp_beat = sb.pop_front();
                chk("out_beat", {31'b0, m_axis_last, m_axis_data}, {31'b0, exp_beat});
            end
        end
    end

    initial begin
        resetn       = 1'b0;
        gate_enable  = 1'b0;
        open_thr     = 23'h100000;
        close_thr    = 23'h080000;
        hold_samples = 16'd2;
        attack_step  = 8'd64;
        release_step = 8'd128;
        s_axis_data  = 32'hDEAD_BEEF;
        s_axis_valid = 1'b1;
        s_axis_last  = 1'b1;
        m_axis_ready = 1'b1;

        // Reset with valid asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_s_ready", {63'b0, s_axis_ready}, 64'd0);
            chk("rst_m_valid", {63'b0, m_axis_valid}, 64'd0);
            chk("rst_m_data",  {32'b0, m_axis_data},  64'd0);
        end
`ifdef NOISE_GATE_STATUS_EN
        chk("rst_gate_open", {62'b0, gate_open}, 64'd0);
`endif
        @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
        resetn       = 1'b1;

        // Bypass: words pass untouched, last copied
        send(32'hAB80_0001, 1'b1, 32'hAB80_0001);
        send(32'h0020_0000, 1'b0, 32'h0020_0000);
        send(32'h1234_5678, 1'b1, 32'h1234_5678);

        // Ramp on ch0 (last=1 keeps every beat on ch0)
        gate_enable = 1'b1;
        send(32'h5A20_0000, 1'b1, 32'h5A08_0000);
        send(32'h5A20_0000, 1'b1, 32'h5A10_0000);
        send(32'h5A20_0000, 1'b1, 32'h5A18_0000);
        send(32'h5A20_0000, 1'b1, 32'h5A20_0000);

        // Hold interrupted by a loud sample, then hold, release, close
        send(32'h0001_0000, 1'b1, 32'h0001_0000);
        send(32'h0020_0000, 1'b1, 32'h0020_0000);
        send(32'h0001_0000, 1'b1, 32'h0001_0000);
        send(32'h0001_0000, 1'b1, 32'h0001_0000);
        send(32'h0001_0000, 1'b1, 32'h0001_0000);
        send(32'h00FF_FFFD, 1'b1, 32'h00FF_FFFE);  // -3*127 >>> 8 = -2
        send(32'h0001_0000, 1'b1, 32'h0000_0000);
        send(32'h0001_0000, 1'b1, 32'h0000_0000);

        // Stereo: ch0 loud ramps, ch1 quiet stays at gain 0
        send(32'h0020_0000, 1'b0, 32'h0008_0000);
        send(32'h0004_0000, 1'b1, 32'h0000_0000);
        send(32'h0020_0000, 1'b0, 32'h0010_0000);
        send(32'h0004_0000, 1'b1, 32'h0000_0000);
        send(32'h0020_0000, 1'b0, 32'h0018_0000);
        send(32'h0004_0000, 1'b1, 32'h0000_0000);
        send(32'h0020_0000, 1'b0, 32'h0020_0000);
        send(32'h0004_0000, 1'b1, 32'h0000_0000);
`ifdef NOISE_GATE_STATUS_EN
        chk("gate_open_stereo", {62'b0, gate_open}, 64'd1);
`endif
        // Short frame on ch0, next beat must land on ch0 again (open -> full level)
        send(32'h0010_0000, 1'b1, 32'h0010_0000);
        send(32'h0004_0000, 1'b0, 32'h0004_0000);
        send(32'h0004_0000, 1'b1, 32'h0000_0000);

        // Backpressure: output held, input stalled, ch1 FSM not advanced
        send(32'h0030_0000, 1'b0, 32'h0030_0000);
        m_axis_ready = 1'b0;
        s_axis_data  = 32'h0020_0000;
        s_axis_last  = 1'b1;
        s_axis_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_m_data",  {32'b0, m_axis_data},  64'h0030_0000);
            chk("bp_m_valid", {63'b0, m_axis_valid}, 64'd1);
            chk("bp_s_ready", {63'b0, s_axis_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        m_axis_ready = 1'b1;
        send(32'h0020_0000, 1'b1, 32'h0008_0000);

        // Force all closed, then saturating abs at the top threshold
        gate_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        gate_enable = 1'b1;
        open_thr    = 23'h7FFFFF;
        attack_step = 8'd255;
        send(32'h0080_0000, 1'b0, 32'h0080_0000);
        send(32'h0080_0002, 1'b1, 32'h0000_0000);
        send(32'h0000_0100, 1'b0, 32'h0000_0100);
        send(32'h007F_FFFF, 1'b1, 32'h007F_FFFF);

        // Drain
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
